// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver with a built-in phase-accumulator oversampling tick,
// two-flop line synchronizer, 3-sample majority filter and frame FSM.
`timescale 1ns/1ps
module uart_rx_8n1 #(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int AccWidth = $clog2(ClkFrequency / Baud + 1) + 8;
  localparam int AccTop   = AccWidth + 1;
  localparam int OsBits   = $clog2(Oversampling);
  // Operands are pre-shifted by 7 so the increment stays inside 32-bit math.
  localparam int PreShift = 7;
  localparam int Inc = ((Baud << (AccWidth + OsBits - PreShift)) +
                        (ClkFrequency >> (PreShift + 1))) /
                       (ClkFrequency >> PreShift);
  localparam logic [AccWidth:0] IncVal = AccTop'(Inc);
  localparam logic [OsBits-1:0] OsHalf = OsBits'(Oversampling / 2 - 1);
  localparam logic [OsBits-1:0] OsLast = OsBits'(Oversampling - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic [AccWidth:0] acc_q, acc_d;
  logic              sync1_q, sync2_q;
  logic [2:0]        hist_q, hist_d;
  state_t            state_q, state_d;
  logic [OsBits-1:0] os_q, os_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              filt;

  assign tick = acc_q[AccWidth];
  assign filt = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                (hist_q[1] & hist_q[2]);

  always_comb begin
    acc_d  = {1'b0, acc_q[AccWidth-1:0]} + IncVal;
    hist_d = hist_q;
    if (tick) begin
      hist_d = {hist_q[1:0], sync2_q};
    end
  end

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!filt) begin
            state_d = START;
            os_d    = '0;
          end
        end
        START: begin
          os_d = os_q + 1'b1;
          if (os_q == OsHalf) begin
            if (!filt) begin
              state_d = DATA;
              os_d    = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          os_d = os_q + 1'b1;
          if (os_q == OsLast) begin
            shift_d = {filt, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          os_d = os_q + 1'b1;
          if (os_q == OsLast) begin
            if (filt) begin
              data_d  = shift_q;
              ready_d = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BREAK;
            end
          end
        end
        BREAK: begin
          if (filt) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_ready = ready_q;
  assign rx_frame_err  = err_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: a 16-clk-per-bit instance for functional
// cases and a default-parameter instance for baud tolerance.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk, clk2, rst_n, rxd, rxd2;
  logic [7:0] rx_data, rx_data2;
  logic       rx_data_ready, rx_data_ready2;
  logic       rx_frame_err, rx_frame_err2;
  logic       rx_busy, rx_busy2;
  bit         clk2_run = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  exp_t       exp_q[$];
  exp_t       exp2_q[$];
  int         ready_cyc[$];
  logic [7:0] last_good [2];
  exp_t       m1_e, m2_e;

  localparam real BitNs  = 16000.0;
  localparam real DefBit = 1.0e9 / 115200.0;

  uart_rx_8n1 #(.ClkFrequency(1000000), .Baud(62500), .Oversampling(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data),
    .rx_data_ready(rx_data_ready), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  uart_rx_8n1 u_dut_def (
    .clk(clk2), .rst_n(rst_n), .rxd(rxd2), .rx_data(rx_data2),
    .rx_data_ready(rx_data_ready2), .rx_frame_err(rx_frame_err2), .rx_busy(rx_busy2)
  );

  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  initial begin
    clk2 = 1'b0;
    while (clk2_run) #20 clk2 = ~clk2;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic driveLine(input bit sel, input logic v);
    if (sel) rxd2 = v;
    else rxd = v;
  endtask

  // Frame is sent; line is left at the stop-bit level on return.
  task automatic applyStimulus(input bit sel, input logic [7:0] data, input logic stop, input real bit_ns);
    exp_t e;
    e.is_err = ~stop;
    e.data   = stop ? data : last_good[sel];
    if (stop) last_good[sel] = data;
    if (sel) exp2_q.push_back(e);
    else exp_q.push_back(e);
    driveLine(sel, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      driveLine(sel, data[i]);
      #(bit_ns);
    end
    driveLine(sel, stop);
    #(bit_ns);
  endtask

  always @(negedge clk) begin
    if (rst_n && (rx_data_ready || rx_frame_err)) begin
      checkOutput("ready_err_exclusive", {31'd0, rx_data_ready & rx_frame_err}, 32'd0);
      checkOutput("strobe_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (rx_data_ready) ready_cyc.push_back(cyc);
      if (exp_q.size() != 0) begin
        m1_e = exp_q.pop_front();
        checkOutput("strobe_kind_err", {31'd0, rx_frame_err}, {31'd0, m1_e.is_err});
        checkOutput("rx_data_at_strobe", {24'd0, rx_data}, {24'd0, m1_e.data});
      end
    end
  end

  always @(negedge clk2) begin
    if (rst_n && (rx_data_ready2 || rx_frame_err2)) begin
      checkOutput("def_strobe_was_expected", {31'd0, exp2_q.size() != 0}, 32'd1);
      if (exp2_q.size() != 0) begin
        m2_e = exp2_q.pop_front();
        checkOutput("def_strobe_kind_err", {31'd0, rx_frame_err2}, {31'd0, m2_e.is_err});
        checkOutput("def_rx_data_at_strobe", {24'd0, rx_data2}, {24'd0, m2_e.data});
      end
    end
  end

  initial begin
    logic [7:0] d55;
    d55 = 8'h55;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    rst_n = 1'b0;
    rxd   = 1'b1;
    rxd2  = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_ready", {31'd0, rx_data_ready}, 32'd0);
    checkOutput("reset_err", {31'd0, rx_frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, rx_busy}, 32'd0);
    checkOutput("def_reset_rx_data", {24'd0, rx_data2}, 32'd0);
    checkOutput("def_reset_busy", {31'd0, rx_busy2}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] default parameters, 0x6E at +3%% and -3%% bit period");
    applyStimulus(1'b1, 8'h6E, 1'b1, DefBit * 1.03);
    #(DefBit * 3.0);
    applyStimulus(1'b1, 8'h6E, 1'b1, DefBit * 0.97);
    #(DefBit * 3.0);
    checkOutput("def_all_strobes_seen", exp2_q.size(), 32'd0);
    checkOutput("def_rx_data_final", {24'd0, rx_data2}, 32'h6E);
    checkOutput("def_busy_idle", {31'd0, rx_busy2}, 32'd0);
    clk2_run = 1'b0;

    $display("[TB] 0xA5 frame");
    @(negedge clk);
    applyStimulus(1'b0, 8'hA5, 1'b1, BitNs);
    repeat (16) @(negedge clk);
    checkOutput("a5_all_strobes_seen", exp_q.size(), 32'd0);
    checkOutput("a5_rx_data", {24'd0, rx_data}, 32'hA5);
    checkOutput("a5_busy_low", {31'd0, rx_busy}, 32'd0);

    $display("[TB] 3-clk glitch");
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (32) @(negedge clk);
    checkOutput("glitch_rx_data", {24'd0, rx_data}, 32'hA5);
    checkOutput("glitch_busy_low", {31'd0, rx_busy}, 32'd0);

    $display("[TB] 0x3C with low stop bit, then break");
    applyStimulus(1'b0, 8'h3C, 1'b0, BitNs);
    repeat (40) @(negedge clk);
    checkOutput("break_busy_high", {31'd0, rx_busy}, 32'd1);
    checkOutput("break_err_seen", exp_q.size(), 32'd0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("break_busy_low", {31'd0, rx_busy}, 32'd0);
    checkOutput("break_rx_data", {24'd0, rx_data}, 32'hA5);

    $display("[TB] back-to-back 0x00 then 0xFF");
    ready_cyc.delete();
    applyStimulus(1'b0, 8'h00, 1'b1, BitNs);
    applyStimulus(1'b0, 8'hFF, 1'b1, BitNs);
    repeat (16) @(negedge clk);
    checkOutput("b2b_all_strobes_seen", exp_q.size(), 32'd0);
    checkOutput("b2b_ready_count", ready_cyc.size(), 32'd2);
    if (ready_cyc.size() == 2)
      checkOutput("b2b_ready_spacing", ready_cyc[1] - ready_cyc[0], 32'd160);
    checkOutput("b2b_rx_data", {24'd0, rx_data}, 32'hFF);

    $display("[TB] reset during bit 4 of 0x55, then 0x81");
    driveLine(1'b0, 1'b0);
    #(BitNs);
    for (int i = 0; i < 4; i++) begin
      driveLine(1'b0, d55[i]);
      #(BitNs);
    end
    driveLine(1'b0, d55[4]);
    #(BitNs / 2.0);
    rst_n = 1'b0;
    rxd = 1'b1;
    last_good[0] = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("midreset_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    checkOutput("midreset_no_strobe", exp_q.size(), 32'd0);
    applyStimulus(1'b0, 8'h81, 1'b1, BitNs);
    repeat (16) @(negedge clk);
    checkOutput("r81_all_strobes_seen", exp_q.size(), 32'd0);
    checkOutput("r81_rx_data", {24'd0, rx_data}, 32'h81);
    checkOutput("r81_busy_low", {31'd0, rx_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Asynchronous serial receiver for 8N1 frames; the receive-side counterpart of the UART transmit path. It contains its own phase-accumulator oversampling tick generator running at Baud × Oversampling, a line synchronizer, a majority filter and a frame state machine. Received bytes are presented with a one-clock strobe to the host logic, and framing errors are flagged separately.

## Interface
- ClkFrequency, 25000000: system clock frequency in Hz.
- Baud, 115200: line bit rate in bit/s.
- Oversampling, 8: ticks per bit period; must be a power of two, 8 or greater.
- clk  input  1  system clock; all flops update on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rxd  input  1  serial line; asynchronous to clk; idles high.
- rx_data  output  8  last received byte; holds until the next valid frame.
- rx_data_ready  output  1  one-clk strobe when rx_data has been updated.
- rx_frame_err  output  1  one-clk strobe when the stop bit is sampled low.
- rx_busy  output  1  high whenever the state machine is not IDLE.

## Operation
- Tick generator:
  - AccWidth = ceil-bit-length(ClkFrequency/Baud) + 8.
  - Acc is AccWidth+1 bits wide. Inc is the rounded value of Baud × Oversampling × 2^AccWidth / ClkFrequency.
  - The Inc calculation must not overflow 32-bit integer arithmetic. Pre-shift the operands to keep it in range.
  - Each clk: Acc <= Acc[AccWidth-1:0] + Inc. tick = Acc[AccWidth].
  - The generator runs freely and has no enable input.
- Synchronizer: two flops on rxd, both reset to 1.
- Filter:
  - On each tick, shift the synchronized bit into a 3-bit history (reset 3'b111).
  - The filtered bit is the majority of the 3 history bits. It is recomputed only on ticks.
- OsCnt: log2(Oversampling) bits, advances only on ticks. BitCnt: 3 bits.
- States:
  - IDLE: when the filtered bit is 0 on a tick, go to START and set OsCnt=0.
  - START: on the tick where OsCnt reaches Oversampling/2-1, examine the filtered bit. If 0, go to DATA with OsCnt=0 and BitCnt=0. If 1, it was a glitch: return to IDLE.
  - DATA: on the tick where OsCnt reaches Oversampling-1, shift the filtered bit in LSB-first. If BitCnt=7, go to STOP. Otherwise increment BitCnt.
  - STOP: on the tick where OsCnt reaches Oversampling-1, examine the filtered bit:
    - If 1: load rx_data from the shift register, pulse rx_data_ready, go to IDLE.
    - If 0: pulse rx_frame_err, leave rx_data unchanged, go to BREAK.
  - BREAK: stay here until a tick sees the filtered bit at 1, then go to IDLE.
- A new start bit may be detected on the first tick after returning to IDLE. There is no inter-frame gap requirement.
- There is no handshake and no overrun detection. The consumer must capture rx_data in the cycle rx_data_ready is high. rx_data stays stable until the next valid frame.
- rx_data_ready and rx_frame_err are never high in the same cycle.

## Timing
- Reset values: rx_data=8'h00, rx_data_ready=0, rx_frame_err=0, rx_busy=0, Acc=0, state=IDLE.
- Deasserting rst_n mid-frame discards the partial byte. No strobe is issued for it.
- Strobes are registered. Each is high for exactly one clk, in the cycle after the tick that sampled the stop bit.
- Latency from the rxd start edge to the filtered bit going low: 2 clk (synchronizer) plus 1–3 ticks (filter). This offset is common to every bit, so sampling stays mid-bit.
- Tolerance: a frame is received correctly with a bit-period error of ±3% at the default parameters.
- rx_busy rises in the cycle after entering START. It falls in the same cycle as the ready/error strobe, or on the BREAK→IDLE transition.

## Test plan
- Bench parameters: ClkFrequency=1000000, Baud=62500, Oversampling=8. This gives Inc=4096, a tick every 2 clk and 16 clk per bit.
- Drive 0xA5 as 8N1 (start bit, 1,0,1,0,0,1,0,1 LSB-first, stop bit) -> exactly one rx_data_ready pulse, rx_data=8'hA5, rx_frame_err never high, rx_busy low afterwards.
- Drive rxd low for 3 clk in idle -> no START entry (or a glitch return to IDLE), no strobes, rx_data unchanged.
- Drive 0x3C with a low stop bit, then hold the line low for 40 clk, then high -> one rx_frame_err pulse, no rx_data_ready, rx_busy high until the line returns high, rx_data keeps its previous value.
- Drive back-to-back frames 0x00 then 0xFF with zero idle gap -> two rx_data_ready pulses 160 clk apart, carrying 8'h00 then 8'hFF.
- Pulse rst_n low during bit 4 of 0x55, then send 0x81 -> no strobe for 0x55, then rx_data=8'h81 with one rx_data_ready.
- Default parameters, 0x6E sent with the bit period stretched by +3%, then shortened by −3% -> rx_data=8'h6E both times, no rx_frame_err.
